// File: rtl/seq_detect_prog.sv
// Programmable serial-bit sequence detector: matches the last N accepted bits
// against a reloadable pattern, with run-time overlap selection and a saturating match count.
module seq_detect_prog #(
    parameter int          N       = 8,
    parameter logic [N-1:0] PAT_RST = N'(8'hFF),
    parameter int          CW      = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [N-1:0]  pat_in,
    input  logic          ovl,
    input  logic          x_valid,
    input  logic          x,
    output logic          y,
    output logic [CW-1:0] match_cnt,
    output logic          primed
);

    localparam int FW = $clog2(N + 1);
    localparam logic [FW-1:0] FULL    = FW'(N);
    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [N-1:0]  pattern;
    logic [N-1:0]  hist;
    logic [FW-1:0] fill;

    logic [N-1:0]  hist_next;
    logic [FW-1:0] fill_next;
    logic [FW-1:0] fill_upd;
    logic          match;

    always_comb begin
        hist_next = {hist[N-2:0], x};
        fill_next = (fill == FULL) ? FULL : fill + 1'b1;
        match     = (fill_next == FULL) && (hist_next == pattern);
        // A non-overlapping match consumes the whole window.
        fill_upd  = (match && !ovl) ? '0 : fill_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pattern   <= PAT_RST;
            hist      <= '0;
            fill      <= '0;
            y         <= 1'b0;
            match_cnt <= '0;
            primed    <= 1'b0;
        end else begin
            y <= 1'b0;
            if (load) begin
                pattern   <= pat_in;
                hist      <= '0;
                fill      <= '0;
                match_cnt <= '0;
                primed    <= 1'b0;
            end else if (x_valid) begin
                hist   <= hist_next;
                fill   <= fill_upd;
                primed <= (fill_upd == FULL);
                y      <= match;
                if (match && (match_cnt != CNT_MAX))
                    match_cnt <= match_cnt + 1'b1;
            end
        end
    end

endmodule
